// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter/sequencer sharing one ram_control word bridge.
// Latency: grant at cycle 0, start at cycle 1, done at 1+N gives ack at 2+N.
// Backpressure: requests are held until ack; one transaction in flight, the loser waits in IDLE.
module ram_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 15,
    parameter int TO_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  p0_rd_req,
    input  logic                  p0_wr_req,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wr_data,
    output logic                  p0_ack,
    output logic                  p0_err,
    output logic [DATA_WIDTH-1:0] p0_rd_data,
    input  logic                  p1_rd_req,
    input  logic                  p1_wr_req,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wr_data,
    output logic                  p1_ack,
    output logic                  p1_err,
    output logic [DATA_WIDTH-1:0] p1_rd_data,
    output logic                  ram_wr_start,
    output logic                  ram_rd_start,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr_base,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr_base,
    output logic [DATA_WIDTH-1:0] ram_wr_data_in,
    input  logic                  ram_wr_done,
    input  logic                  ram_rd_done,
    input  logic [DATA_WIDTH-1:0] ram_rd_data_out,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                state;
    state_t                state_nxt;

    logic                  rr_ptr;      // port that wins the next tie
    logic                  owner;       // port of the transaction in flight
    logic                  op_wr;       // 1 = write, 0 = read
    logic                  timed_out;
    logic [TO_WIDTH-1:0]   to_cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] p0_rd_q;
    logic [DATA_WIDTH-1:0] p1_rd_q;

    logic                  req0;
    logic                  req1;
    logic                  any_req;
    logic                  grant_port;
    logic                  grant_wr;
    logic                  done_match;
    logic                  to_hit;

    // Arbitration and completion decode
    always_comb begin
        req0       = p0_rd_req | p0_wr_req;
        req1       = p1_rd_req | p1_wr_req;
        any_req    = req0 | req1;
        // A tie goes to rr_ptr; otherwise whoever is asking (port 1 if only it asks)
        grant_port = (req0 && req1) ? rr_ptr : req1;
        // Write wins over a simultaneous read from the same port
        grant_wr   = grant_port ? p1_wr_req : p0_wr_req;
        // A done for the other op type is ignored
        done_match = op_wr ? ram_wr_done : ram_rd_done;
        // Counter holds the number of WAIT cycles already spent
        to_hit     = (to_cnt == TO_WIDTH'(TIMEOUT - 1));
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-state strobes
    always_comb begin
        state_nxt    = state;
        ram_wr_start = 1'b0;
        ram_rd_start = 1'b0;
        p0_ack       = 1'b0;
        p1_ack       = 1'b0;
        p0_err       = 1'b0;
        p1_err       = 1'b0;
        busy         = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                busy         = 1'b1;
                ram_wr_start = op_wr;
                ram_rd_start = !op_wr;
                state_nxt    = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (done_match || to_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                busy      = 1'b1;
                p0_ack    = !owner;
                p1_ack    = owner;
                p0_err    = !owner && timed_out;
                p1_err    = owner && timed_out;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Transaction latch, round-robin pointer, timeout counter and read-data capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr    <= 1'b0;
            owner     <= 1'b0;
            op_wr     <= 1'b0;
            timed_out <= 1'b0;
            to_cnt    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            p0_rd_q   <= '0;
            p1_rd_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner     <= grant_port;
                        rr_ptr    <= !grant_port;
                        op_wr     <= grant_wr;
                        addr_q    <= grant_port ? p1_addr : p0_addr;
                        wdata_q   <= grant_port ? p1_wr_data : p0_wr_data;
                        to_cnt    <= '0;
                        timed_out <= 1'b0;
                    end
                end
                WAIT: begin
                    to_cnt <= to_cnt + TO_WIDTH'(1);
                    if (done_match) begin
                        // A done on the timeout edge still counts as success
                        timed_out <= 1'b0;
                        if (!op_wr) begin
                            if (owner) begin
                                p1_rd_q <= ram_rd_data_out;
                            end else begin
                                p0_rd_q <= ram_rd_data_out;
                            end
                        end
                    end else if (to_hit) begin
                        timed_out <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Latched values stay on the RAM side until the next grant
    assign ram_wr_addr_base = addr_q;
    assign ram_rd_addr_base = addr_q;
    assign ram_wr_data_in   = wdata_q;
    assign p0_rd_data       = p0_rd_q;
    assign p1_rd_data       = p1_rd_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural ram_control and a response scoreboard.
// Expected acks are queued when requests are raised and popped in order on each ack.
// The RAM model answers starts after a programmable delay, or never, to force timeouts.
module tb_ram_arbiter;

    logic        clk;
    logic        reset_n;
    logic        p0_rd_req, p0_wr_req, p1_rd_req, p1_wr_req;
    logic [31:0] p0_addr, p1_addr, p0_wr_data, p1_wr_data;
    logic        p0_ack, p0_err, p1_ack, p1_err;
    logic [31:0] p0_rd_data, p1_rd_data;
    logic        ram_wr_start, ram_rd_start;
    logic [31:0] ram_wr_addr_base, ram_rd_addr_base, ram_wr_data_in;
    logic        ram_wr_done, ram_rd_done;
    logic [31:0] ram_rd_data_out;
    logic        busy;

    ram_arbiter dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .p0_rd_req        (p0_rd_req),
        .p0_wr_req        (p0_wr_req),
        .p0_addr          (p0_addr),
        .p0_wr_data       (p0_wr_data),
        .p0_ack           (p0_ack),
        .p0_err           (p0_err),
        .p0_rd_data       (p0_rd_data),
        .p1_rd_req        (p1_rd_req),
        .p1_wr_req        (p1_wr_req),
        .p1_addr          (p1_addr),
        .p1_wr_data       (p1_wr_data),
        .p1_ack           (p1_ack),
        .p1_err           (p1_err),
        .p1_rd_data       (p1_rd_data),
        .ram_wr_start     (ram_wr_start),
        .ram_rd_start     (ram_rd_start),
        .ram_wr_addr_base (ram_wr_addr_base),
        .ram_rd_addr_base (ram_rd_addr_base),
        .ram_wr_data_in   (ram_wr_data_in),
        .ram_wr_done      (ram_wr_done),
        .ram_rd_done      (ram_rd_done),
        .ram_rd_data_out  (ram_rd_data_out),
        .busy             (busy)
    );

    typedef struct {
        int          port;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        int          lat;    // -1: latency not checked
        int          t0;
    } exp_t;

    exp_t sb[$];
    exp_t mon_f;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // RAM model controls and state
    int          lat_cfg = 3;
    bit          resp_en = 1'b1;
    bit          spurious = 1'b0;
    bit          pend = 1'b0;
    bit          pend_wr = 1'b0;
    int          scyc = 0;
    logic [31:0] paddr, pdata;
    logic [31:0] mem [logic [31:0]];
    logic        start_prev = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] fill(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural ram_control: answers a start lat_cfg cycles later
    always @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend            = 1'b0;
            ram_wr_done     = 1'b0;
            ram_rd_done     = 1'b0;
            ram_rd_data_out = 32'h0;
        end else begin
            ram_wr_done     = 1'b0;
            ram_rd_done     = 1'b0;
            ram_rd_data_out = 32'hDEAD0000;
            if (ram_wr_start || ram_rd_start) begin
                pend    = resp_en;
                pend_wr = ram_wr_start;
                scyc    = cyc;
                paddr   = ram_wr_addr_base;
                pdata   = ram_wr_data_in;
            end else if (pend) begin
                if (!pend_wr && spurious && cyc == scyc + 1) ram_wr_done = 1'b1;
                if (cyc == scyc + lat_cfg) begin
                    pend = 1'b0;
                    if (pend_wr) begin
                        ram_wr_done = 1'b1;
                        mem[paddr]  = pdata;
                    end else begin
                        ram_rd_done     = 1'b1;
                        ram_rd_data_out = mem.exists(paddr) ? mem[paddr] : fill(paddr);
                    end
                end
            end
        end
    end

    // Monitor: start contents and ack ordering against the scoreboard
    always @(negedge clk) begin
        if (reset_n && (ram_wr_start || ram_rd_start)) begin
            chk("start_width", start_prev, 1'b0);
            chk("start_both", ram_wr_start & ram_rd_start, 1'b0);
            if (sb.size() == 0) begin
                chk("start_unexpected", 1'b1, 1'b0);
            end else begin
                chk("start_op", ram_wr_start, sb[0].wr);
                chk("start_addr", ram_wr_addr_base, sb[0].addr);
                chk("start_rd_addr", ram_rd_addr_base, sb[0].addr);
                if (sb[0].wr) chk("start_wdata", ram_wr_data_in, sb[0].wdata);
            end
        end
        start_prev = ram_wr_start | ram_rd_start;
        if (p0_ack || p1_ack) begin
            chk("ack_both", p0_ack & p1_ack, 1'b0);
            chk("ack_busy", busy, 1'b1);
            if (sb.size() == 0) begin
                chk("ack_unexpected", 1'b1, 1'b0);
            end else begin
                mon_f = sb.pop_front();
                chk("ack_port", p1_ack ? 1 : 0, mon_f.port);
                chk("ack_err", p1_ack ? p1_err : p0_err, mon_f.err);
                chk("ack_other_err", p1_ack ? p0_err : p1_err, 1'b0);
                if (!mon_f.wr && !mon_f.err)
                    chk("ack_rdata", p1_ack ? p1_rd_data : p0_rd_data, mon_f.rdata);
                if (mon_f.lat >= 0) chk("ack_latency", cyc - mon_f.t0, mon_f.lat);
            end
        end
    end

    task automatic push(input int p, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic err, input logic [31:0] rd, input int lat);
        exp_t e;
        e.port = p; e.wr = wr; e.addr = a; e.wdata = d;
        e.err = err; e.rdata = rd; e.lat = lat; e.t0 = cyc;
        sb.push_back(e);
    endtask

    task automatic set_req(input int p, input logic wr, input logic rd,
                           input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            p0_wr_req = wr; p0_rd_req = rd; p0_addr = a; p0_wr_data = d;
        end else begin
            p1_wr_req = wr; p1_rd_req = rd; p1_addr = a; p1_wr_data = d;
        end
    endtask

    function automatic logic ack_of(input int p);
        return (p == 0) ? p0_ack : p1_ack;
    endfunction

    // Returns just after the edge that ends the ack cycle
    task automatic wait_ack(input int p, input string tag);
        int n = 0;
        @(negedge clk);
        while (!ack_of(p) && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk(tag, ack_of(p), 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input int p, input logic wr, input logic rd,
                       input logic [31:0] a, input logic [31:0] d, input string tag);
        set_req(p, wr, rd, a, d);
        wait_ack(p, tag);
        set_req(p, 1'b0, 1'b0, a, d);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_strobes"}, {p0_ack, p1_ack, p0_err, p1_err, ram_wr_start, ram_rd_start, busy}, 7'd0);
        chk({tag, "_addr"}, {ram_wr_addr_base, ram_rd_addr_base}, 64'd0);
        chk({tag, "_wdata"}, ram_wr_data_in, 32'd0);
        chk({tag, "_rdata"}, {p0_rd_data, p1_rd_data}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        p0_rd_req = 0; p0_wr_req = 0; p1_rd_req = 0; p1_wr_req = 0;
        p0_addr = 0; p1_addr = 0; p0_wr_data = 0; p1_wr_data = 0;
        ram_wr_done = 0; ram_rd_done = 0; ram_rd_data_out = 0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1 chk_reset_outputs("reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk_reset_outputs("idle");

        // Write from port 0, done three cycles after start
        push(0, 1'b1, 32'd4086, 32'hAABBCCDD, 1'b0, 32'h0, 5);
        txn(0, 1'b1, 1'b0, 32'd4086, 32'hAABBCCDD, "p0_wr_ack");

        // Read back through port 1; data must persist and port 0 stays clear
        push(1, 1'b0, 32'd4086, 32'h0, 1'b0, 32'hAABBCCDD, 5);
        txn(1, 1'b0, 1'b1, 32'd4086, 32'h0, "p1_rd_ack");
        repeat (3) @(posedge clk);
        #1;
        chk("p1_rdata_held", p1_rd_data, 32'hAABBCCDD);
        chk("p0_rdata_untouched", p0_rd_data, 32'h0);

        // Simultaneous reads with immediate re-request; stray write-done injected
        spurious = 1'b1;
        push(0, 1'b0, 32'd100, 32'h0, 1'b0, fill(32'd100), -1);
        push(1, 1'b0, 32'd200, 32'h0, 1'b0, fill(32'd200), -1);
        push(0, 1'b0, 32'd102, 32'h0, 1'b0, fill(32'd102), -1);
        push(1, 1'b0, 32'd202, 32'h0, 1'b0, fill(32'd202), -1);
        fork
            begin
                txn(0, 1'b0, 1'b1, 32'd100, 32'h0, "rr_p0_a");
                txn(0, 1'b0, 1'b1, 32'd102, 32'h0, "rr_p0_b");
            end
            begin
                txn(1, 1'b0, 1'b1, 32'd200, 32'h0, "rr_p1_a");
                txn(1, 1'b0, 1'b1, 32'd202, 32'h0, "rr_p1_b");
            end
        join
        spurious = 1'b0;

        // Write and read raised together: write first, then the read sees it
        push(1, 1'b1, 32'd55, 32'h12345678, 1'b0, 32'h0, -1);
        push(1, 1'b0, 32'd55, 32'h12345678, 1'b0, 32'h12345678, -1);
        set_req(1, 1'b1, 1'b1, 32'd55, 32'h12345678);
        wait_ack(1, "wr55_ack");
        p1_wr_req = 1'b0;
        wait_ack(1, "rd55_ack");
        set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);

        // No done returned: error ack at 2+TIMEOUT, read data untouched
        resp_en = 1'b0;
        push(0, 1'b0, 32'd7, 32'h0, 1'b1, 32'h0, 17);
        txn(0, 1'b0, 1'b1, 32'd7, 32'h0, "timeout_ack");
        chk("timeout_rdata_kept", p0_rd_data, fill(32'd102));

        // Reset in the middle of WAIT abandons the transaction
        push(0, 1'b0, 32'd9, 32'h0, 1'b1, 32'h0, 17);
        set_req(0, 1'b0, 1'b1, 32'd9, 32'h0);
        repeat (6) @(posedge clk);
        chk("wait_busy", busy, 1'b1);
        #3 reset_n = 1'b0;
        sb.delete();
        #1 chk_reset_outputs("midwait_reset");
        set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        resp_en = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_reset_idle", busy, 1'b0);
        chk("scoreboard_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-port round-robin arbiter and sequencer in front of ram_control, which bridges 32-bit words onto the 16-bit block RAM.
- Lets two requesters share the single backing RAM: port 0 for instruction-cache refill, port 1 for data-cache refill and writeback.
- Per transaction it latches the request, issues one start pulse to ram_control, waits for the matching done, returns data/ack to the owner and handles timeouts.

Parameters:
- ADDR_WIDTH, 32, width of all address ports.
- DATA_WIDTH, 32, width of requester data and ram_control word data.
- TIMEOUT, 15, maximum cycles spent in WAIT before the arbiter forces an error response.
- TO_WIDTH, 4, width of the timeout counter; must satisfy TIMEOUT < 2**TO_WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- p0_rd_req / p1_rd_req  in  1  read request, held until ack.
- p0_wr_req / p1_wr_req  in  1  write request, held until ack.
- p0_addr / p1_addr  in  ADDR_WIDTH  word base address.
- p0_wr_data / p1_wr_data  in  DATA_WIDTH  write word.
- p0_ack / p1_ack  out  1  one-cycle completion pulse.
- p0_err / p1_err  out  1  pulses with ack on timeout.
- p0_rd_data / p1_rd_data  out  DATA_WIDTH  read word; valid with ack, held until that port's next read ack.
- ram_wr_start  out  1  one-cycle write start to ram_control.
- ram_rd_start  out  1  one-cycle read start to ram_control.
- ram_wr_addr_base  out  ADDR_WIDTH  latched address.
- ram_rd_addr_base  out  ADDR_WIDTH  latched address, same value as ram_wr_addr_base.
- ram_wr_data_in  out  DATA_WIDTH  latched write word.
- ram_wr_done  in  1  write-complete pulse from ram_control.
- ram_rd_done  in  1  read-complete pulse from ram_control.
- ram_rd_data_out  in  DATA_WIDTH  read word, valid with ram_rd_done.
- busy  out  1  high in ISSUE, WAIT and RESP.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, rr_ptr=0, timeout counter=0.
  - All outputs 0, including the latched address, data and both rd_data registers.
  - An in-flight transaction is abandoned with no ack; ram_control shares reset_n.
- IDLE:
  - Requests are sampled only in this state.
  - A port requests if rd_req|wr_req is high.
  - One port requesting: grant that port.
  - Both ports requesting: grant port rr_ptr, then set rr_ptr to the other port.
  - A single-port grant also sets rr_ptr to the non-granted port.
  - wr_req and rd_req both high on the granted port: the write wins; the read stays pending and is serviced in a later transaction.
  - On grant: latch owner, op, addr and wr_data; clear the counter; go to ISSUE.
  - No request: stay in IDLE.
- ISSUE (1 cycle):
  - Assert ram_wr_start or ram_rd_start per the latched op, high for exactly this cycle.
  - Go to WAIT.
- WAIT:
  - Counter increments every cycle.
  - Matching done (ram_wr_done for a write, ram_rd_done for a read) goes to RESP.
  - On a read, ram_rd_data_out is captured into the owner's rd_data register on that edge.
  - A non-matching done is ignored.
  - Counter reaching TIMEOUT without a matching done: go to RESP with the error flag set; rd_data is not updated.
  - A done arriving on the same edge as the timeout takes priority, so no error is flagged.
- RESP (1 cycle):
  - Owner's ack=1, and err=1 if timed out; the other port's ack and err stay 0.
  - Go to IDLE.
- Address and data outputs hold their latched values from ISSUE through RESP and until the next grant, so they are stable for ram_control's two-halfword sequence.
- Requester contract: deassert the serviced req on the edge ending the ack cycle. Because IDLE follows RESP, a still-high req is treated as a new request.
- Latency: request visible in IDLE at cycle 0; start at cycle 1; done at cycle 1+N gives ack at cycle 2+N.
- Minimum gap between back-to-back grants is one IDLE cycle.
- Addresses pass through unmodified; no range or alignment checking (ram_control owns wrap behaviour).

Test Plan:
- Reset, no requests → all outputs 0 and busy=0; release reset, idle 3 cycles → outputs unchanged.
- p0_wr_req with addr 4086, data 0xAABBCCDD; model raises ram_wr_done 3 cycles after start → ram_wr_start for one cycle with ram_wr_addr_base=4086 and ram_wr_data_in=0xAABBCCDD; p0_ack at cycle 5; p0_err=0.
- Then p1_rd_req with addr 4086 → ram_rd_start pulse; p1_rd_data=0xAABBCCDD with p1_ack; value held afterwards; p0_rd_data stays 0.
- p0 and p1 raise reads in the same cycle and re-request immediately after each ack → grants ordered p0, p1, p0, p1; a spurious ram_wr_done during a read is ignored.
- p1 raises wr_req and rd_req together at addr 55 → write serviced first, read second.
- No done returned → p0_ack and p0_err at cycle 2+TIMEOUT (cycle 17 at default); rd_data unchanged. Repeat, asserting reset_n=0 mid-WAIT → immediate IDLE, no ack, outputs 0.
